// File: rtl/debounce_defs_pkg.sv
// Shared state encoding for the switch debouncer; the bench imports it too
// so state checks use the same names as the RTL.
package debounce_defs;

   localparam logic [1:0] ZERO  = 2'b00;
   localparam logic [1:0] WAIT1 = 2'b01;
   localparam logic [1:0] ONE   = 2'b10;
   localparam logic [1:0] WAIT0 = 2'b11;

endpackage

// File: rtl/debounce_fsm_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, async active-high reset.
module sync_2ff (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/debounce_fsm.sv
// Switch debouncer: a new synchronized level must hold STABLE_CNT+1 samples
// before db_level follows it; rise/fall ticks mark each accepted change.
//
//   state | meaning
//   ZERO  | settled low, counter holds
//   WAIT1 | candidate high being timed
//   ONE   | settled high, counter holds
//   WAIT0 | candidate low being timed
module debounce_fsm
   import debounce_defs::*;
#(
   parameter int STABLE_CNT = 1000000
) (
   input  logic clk,
   input  logic reset,
   input  logic sw,
   output logic db_level,
   output logic db_rise,
   output logic db_fall,
   output logic busy
);

   localparam int CNT_W = $clog2(STABLE_CNT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

   logic             sw_s;
   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             db_level_q, db_level_d;
   logic             db_rise_q, db_rise_d;
   logic             db_fall_q, db_fall_d;
   logic             busy_q, busy_d;

   sync_2ff u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (sw),
      .q     (sw_s)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ZERO: begin
            if (sw_s) begin
               state_d = WAIT1;
               cnt_d   = '0;
            end
         end
         WAIT1: begin
            if (!sw_s)                 state_d = ZERO;
            else if (cnt_q == CNT_LAST) state_d = ONE;
            else                        cnt_d   = cnt_q + CNT_W'(1);
         end
         ONE: begin
            if (!sw_s) begin
               state_d = WAIT0;
               cnt_d   = '0;
            end
         end
         WAIT0: begin
            if (sw_s)                   state_d = ONE;
            else if (cnt_q == CNT_LAST) state_d = ZERO;
            else                        cnt_d   = cnt_q + CNT_W'(1);
         end
         default: state_d = ZERO;
      endcase

      // Outputs are decoded from the next state so they are registered yet
      // line up with the state transition.
      db_level_d = (state_d == ONE) || (state_d == WAIT0);
      busy_d     = (state_d == WAIT1) || (state_d == WAIT0);
      db_rise_d  = (state_q == WAIT1) && (state_d == ONE);
      db_fall_d  = (state_q == WAIT0) && (state_d == ZERO);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ZERO;
         cnt_q      <= '0;
         db_level_q <= 1'b0;
         db_rise_q  <= 1'b0;
         db_fall_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         db_level_q <= db_level_d;
         db_rise_q  <= db_rise_d;
         db_fall_q  <= db_fall_d;
         busy_q     <= busy_d;
      end
   end

   assign db_level = db_level_q;
   assign db_rise  = db_rise_q;
   assign db_fall  = db_fall_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_debounce_fsm.sv
// Self-checking bench for debounce_fsm with STABLE_CNT=4, using a run-length
// reference model of the accept rule plus directed latency/glitch scenarios.
module tb_debounce_fsm;
   import debounce_defs::*;

   localparam int STABLE = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic sw = 1'b0;
   logic db_level, db_rise, db_fall, busy;

   int vectors = 0;
   int errors  = 0;

   // reference model state
   logic h1, h2;
   logic ref_level, ref_rise, ref_fall, ref_busy;
   int   run;

   debounce_fsm #(.STABLE_CNT(STABLE)) dut (
      .clk      (clk),
      .reset    (reset),
      .sw       (sw),
      .db_level (db_level),
      .db_rise  (db_rise),
      .db_fall  (db_fall),
      .busy     (busy)
   );

   always #10 clk = ~clk;

   task automatic model_reset();
      h1 = 1'b0; h2 = 1'b0; run = 0;
      ref_level = 1'b0; ref_rise = 1'b0; ref_fall = 1'b0; ref_busy = 1'b0;
   endtask

   // The FSM sees sw two edges late; a level change is accepted once the
   // seen value has differed from the current level on STABLE+1 consecutive edges.
   task automatic model_edge(input logic v);
      logic seen;
      seen = h2;
      h2 = h1;
      h1 = v;
      ref_rise = 1'b0;
      ref_fall = 1'b0;
      if (seen != ref_level) begin
         run++;
         if (run == STABLE + 1) begin
            ref_level = seen;
            ref_rise  = seen;
            ref_fall  = !seen;
            run       = 0;
         end
      end else begin
         run = 0;
      end
      ref_busy = (run != 0);
   endtask

   function automatic logic [1:0] exp_state();
      if (!ref_level) return ref_busy ? WAIT1 : ZERO;
      else            return ref_busy ? WAIT0 : ONE;
   endfunction

   task automatic step(input logic v);
      sw = v;
      @(posedge clk);
      model_edge(v);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      model_reset();
      @(negedge clk);
      @(negedge clk);
      vectors++;
      if ({db_level, db_rise, db_fall, busy} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_outputs: got %b exp 0000", {db_level, db_rise, db_fall, busy});
      end
      vectors++;
      if (dut.state_q !== ZERO) begin
         errors++;
         $display("FAIL reset_state: got %b exp %b", dut.state_q, ZERO);
      end
      vectors++;
      if (dut.cnt_q !== 2'd0) begin
         errors++;
         $display("FAIL reset_cnt: got %0d exp 0", dut.cnt_q);
      end
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_clean_press();
      for (int i = 1; i <= 9; i++) begin
         step(1'b1);
         vectors++;
         if ({db_level, db_rise, db_fall, busy} !== {ref_level, ref_rise, ref_fall, ref_busy}) begin
            errors++;
            $display("FAIL press_model edge %0d: got %b exp %b", i,
                     {db_level, db_rise, db_fall, busy}, {ref_level, ref_rise, ref_fall, ref_busy});
         end
         if (i == 3) begin
            vectors++;
            if (busy !== 1'b1) begin
               errors++;
               $display("FAIL press_busy_e3: got %b exp 1", busy);
            end
         end
         if (i == 6 || i == 7) begin
            vectors++;
            if ({db_level, db_rise} !== ((i == 7) ? 2'b11 : 2'b00)) begin
               errors++;
               $display("FAIL press_latency edge %0d: got %b", i, {db_level, db_rise});
            end
         end
         if (i == 8) begin
            vectors++;
            if (db_rise !== 1'b0) begin
               errors++;
               $display("FAIL press_rise_width: got %b exp 0", db_rise);
            end
         end
         vectors++;
         if (db_fall !== 1'b0) begin
            errors++;
            $display("FAIL press_no_fall edge %0d: got %b exp 0", i, db_fall);
         end
      end
   endtask

   task automatic test_bounce();
      logic pat [8];
      pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      do_reset();
      for (int i = 0; i < 8; i++) begin
         step(pat[i]);
         vectors++;
         if ({db_level, db_rise, db_fall, busy} !== {ref_level, ref_rise, ref_fall, ref_busy} ||
             db_rise !== 1'b0 || db_level !== 1'b0) begin
            errors++;
            $display("FAIL bounce_quiet step %0d: got %b exp %b", i,
                     {db_level, db_rise, db_fall, busy}, {ref_level, ref_rise, ref_fall, ref_busy});
         end
      end
      for (int k = 1; k <= 9; k++) begin
         step(1'b1);
         vectors++;
         if ({db_level, db_rise, db_fall, busy} !== {ref_level, ref_rise, ref_fall, ref_busy}) begin
            errors++;
            $display("FAIL bounce_model edge %0d: got %b exp %b", k,
                     {db_level, db_rise, db_fall, busy}, {ref_level, ref_rise, ref_fall, ref_busy});
         end
         if (k == 6 || k == 7) begin
            vectors++;
            if ({db_level, db_rise} !== ((k == 7) ? 2'b11 : 2'b00)) begin
               errors++;
               $display("FAIL bounce_latency edge %0d: got %b", k, {db_level, db_rise});
            end
         end
      end
   endtask

   task automatic test_release();
      for (int k = 1; k <= 9; k++) begin
         step(1'b0);
         vectors++;
         if ({db_level, db_rise, db_fall, busy} !== {ref_level, ref_rise, ref_fall, ref_busy}) begin
            errors++;
            $display("FAIL release_model edge %0d: got %b exp %b", k,
                     {db_level, db_rise, db_fall, busy}, {ref_level, ref_rise, ref_fall, ref_busy});
         end
         if (k == 6 || k == 7 || k == 8) begin
            vectors++;
            if ({db_level, db_fall} !== ((k == 6) ? 2'b10 : (k == 7) ? 2'b01 : 2'b00)) begin
               errors++;
               $display("FAIL release_latency edge %0d: got level/fall %b", k, {db_level, db_fall});
            end
         end
      end
   endtask

   task automatic test_glitch();
      logic busy_seen;
      busy_seen = 1'b0;
      for (int k = 1; k <= 8; k++) step(1'b1);
      vectors++;
      if (db_level !== 1'b1) begin
         errors++;
         $display("FAIL glitch_setup: got level %b exp 1", db_level);
      end
      for (int k = 0; k < 13; k++) begin
         step((k < 3) ? 1'b0 : 1'b1);
         busy_seen = busy_seen | busy;
         vectors++;
         if (db_level !== 1'b1 || db_fall !== 1'b0 || db_rise !== 1'b0 || busy !== ref_busy) begin
            errors++;
            $display("FAIL glitch_hold step %0d: got level %b fall %b rise %b busy %b exp 1 0 0 %b",
                     k, db_level, db_fall, db_rise, busy, ref_busy);
         end
      end
      vectors++;
      if (busy_seen !== 1'b1) begin
         errors++;
         $display("FAIL glitch_busy_pulse: got %b exp 1", busy_seen);
      end
   endtask

   task automatic test_reset_mid_wait();
      do_reset();
      for (int k = 1; k <= 5; k++) step(1'b1);
      vectors++;
      if (dut.state_q !== WAIT1 || dut.cnt_q !== 2'd2 || busy !== 1'b1) begin
         errors++;
         $display("FAIL midwait_setup: got state %b cnt %0d busy %b exp %b 2 1",
                  dut.state_q, dut.cnt_q, busy, WAIT1);
      end
      #3 reset = 1'b1;
      #1;
      vectors++;
      if ({db_level, db_rise, db_fall, busy} !== 4'b0000 || dut.state_q !== ZERO || dut.cnt_q !== 2'd0) begin
         errors++;
         $display("FAIL midwait_async_reset: got outs %b state %b cnt %0d exp 0000 %b 0",
                  {db_level, db_rise, db_fall, busy}, dut.state_q, dut.cnt_q, ZERO);
      end
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      for (int k = 1; k <= 8; k++) begin
         step(1'b1);
         vectors++;
         if ({db_level, db_rise, db_fall, busy} !== {ref_level, ref_rise, ref_fall, ref_busy}) begin
            errors++;
            $display("FAIL midwait_model edge %0d: got %b exp %b", k,
                     {db_level, db_rise, db_fall, busy}, {ref_level, ref_rise, ref_fall, ref_busy});
         end
         if (k == 6 || k == 7) begin
            vectors++;
            if (db_level !== ((k == 7) ? 1'b1 : 1'b0)) begin
               errors++;
               $display("FAIL midwait_requalify edge %0d: got level %b", k, db_level);
            end
         end
      end
   endtask

   task automatic test_random();
      logic val, prev_level, prev_tick, tick;
      int   left;
      do_reset();
      val = 1'b0;
      left = 0;
      prev_level = 1'b0;
      prev_tick = 1'b0;
      for (int c = 0; c < 200; c++) begin
         if (left == 0) begin
            val  = ~val;
            left = $urandom_range(1, 8);
         end
         left--;
         step(val);
         tick = db_rise | db_fall;
         vectors++;
         if ({db_level, db_rise, db_fall, busy} !== {ref_level, ref_rise, ref_fall, ref_busy} ||
             dut.state_q !== exp_state()) begin
            errors++;
            $display("FAIL random_model cycle %0d: got %b state %b exp %b state %b", c,
                     {db_level, db_rise, db_fall, busy}, dut.state_q,
                     {ref_level, ref_rise, ref_fall, ref_busy}, exp_state());
         end
         vectors++;
         if ((db_rise & db_fall) !== 1'b0 || (tick & prev_tick) !== 1'b0 ||
             (db_level != prev_level) !== tick) begin
            errors++;
            $display("FAIL random_ticks cycle %0d: got rise %b fall %b prev_tick %b level %b prev_level %b",
                     c, db_rise, db_fall, prev_tick, db_level, prev_level);
         end
         prev_level = db_level;
         prev_tick  = tick;
      end
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_release();
      test_glitch();
      test_reset_mid_wait();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
